// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: control/status bundle between the multicycle controller and its datapath.
interface multicycle_ctrl_if #(parameter int OPW = 4);
    logic [OPW-1:0] opcode;
    logic zero;
    logic mem_ready;
    logic pc_we;
    logic ir_we;
    logic iord;
    logic mem_rd;
    logic mem_wr;
    logic reg_we;
    logic reg_dst;
    logic mem_to_reg;
    logic alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic halted;
    logic [3:0] state;
    modport master (
        input opcode, zero, mem_ready,
        output pc_we, ir_we, iord, mem_rd, mem_wr, reg_we, reg_dst, mem_to_reg,
        output alu_src_a, alu_src_b, alu_op, pc_src, halted, state
    );
    modport slave (
        output opcode, zero, mem_ready,
        input pc_we, ir_we, iord, mem_rd, mem_wr, reg_we, reg_dst, mem_to_reg,
        input alu_src_a, alu_src_b, alu_op, pc_src, halted, state
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore FSM sequencing fetch/decode/execute/memory/writeback of the 16-bit multicycle core.
module multicycle_ctrl #(
    parameter bit ILLEGAL_HALT = 1'b0,
    parameter int OPW = 4
) (
    input logic clk,
    input logic rst,
    multicycle_ctrl_if.master bus
);
    typedef enum logic [3:0] {
        FETCH = 4'd0, DECODE = 4'd1, EXEC_R = 4'd2, EXEC_I = 4'd3,
        ALU_WB = 4'd4, MEM_ADDR = 4'd5, MEM_LD = 4'd6, LD_WB = 4'd7,
        MEM_ST = 4'd8, BRANCH = 4'd9, JUMP = 4'd10, HALT = 4'd11
    } state_t;
    state_t state;
    logic r_type;
    logic [OPW-1:0] op;
    assign op = bus.opcode;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FETCH;
            r_type <= 1'b0;
        end else begin
            case (state)
                FETCH: state <= bus.mem_ready ? DECODE : FETCH;
                DECODE: begin
                    r_type <= op < OPW'(4);
                    state <= op < OPW'(4) ? EXEC_R :
                             op == OPW'(4) ? EXEC_I :
                             (op == OPW'(5) || op == OPW'(6)) ? MEM_ADDR :
                             op == OPW'(7) ? BRANCH :
                             op == OPW'(8) ? JUMP :
                             (&op || ILLEGAL_HALT) ? HALT : FETCH;
                end
                EXEC_R, EXEC_I: state <= ALU_WB;
                MEM_ADDR: state <= op == OPW'(5) ? MEM_LD : MEM_ST;
                MEM_LD: state <= bus.mem_ready ? LD_WB : MEM_LD;
                MEM_ST: state <= bus.mem_ready ? FETCH : MEM_ST;
                HALT: state <= HALT;
                // single-cycle tail states and any unused encoding fall back to FETCH
                default: state <= FETCH;
            endcase
        end
    end
    always_comb begin
        bus.pc_we = 1'b0;
        bus.ir_we = 1'b0;
        bus.iord = 1'b0;
        bus.mem_rd = 1'b0;
        bus.mem_wr = 1'b0;
        bus.reg_we = 1'b0;
        bus.reg_dst = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.alu_src_a = 1'b0;
        bus.alu_src_b = 2'b00;
        bus.alu_op = 2'b00;
        bus.pc_src = 2'b00;
        bus.halted = 1'b0;
        case (state)
            FETCH: begin
                bus.mem_rd = 1'b1;
                bus.alu_src_b = 2'b01;
                bus.ir_we = bus.mem_ready;
                bus.pc_we = bus.mem_ready;
            end
            DECODE: bus.alu_src_b = 2'b10;
            EXEC_R: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op = 2'b10;
            end
            EXEC_I, MEM_ADDR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
            end
            ALU_WB: begin
                bus.reg_we = 1'b1;
                bus.reg_dst = r_type;
            end
            MEM_LD: begin
                bus.iord = 1'b1;
                bus.mem_rd = 1'b1;
            end
            LD_WB: begin
                bus.reg_we = 1'b1;
                bus.mem_to_reg = 1'b1;
            end
            MEM_ST: begin
                bus.iord = 1'b1;
                bus.mem_wr = 1'b1;
            end
            BRANCH: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op = 2'b01;
                bus.pc_src = 2'b01;
                bus.pc_we = bus.zero;
            end
            JUMP: begin
                bus.pc_src = 2'b10;
                bus.pc_we = 1'b1;
            end
            HALT: bus.halted = 1'b1;
            default: ;
        endcase
    end
    assign bus.state = state;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: random instruction stream checked against a per-instruction latency and
// enable-count model, plus directed reset, halt and illegal-opcode cases.
module tb_multicycle_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    multicycle_ctrl_if b0();
    multicycle_ctrl_if b1();
    multicycle_ctrl #(.ILLEGAL_HALT(1'b0), .OPW(4)) dut (.clk(clk), .rst(rst), .bus(b0.master));
    multicycle_ctrl #(.ILLEGAL_HALT(1'b1), .OPW(4)) dut_h (.clk(clk), .rst(rst), .bus(b1.master));
    assign b1.opcode = b0.opcode;
    assign b1.zero = b0.zero;
    assign b1.mem_ready = b0.mem_ready;

    int compared = 0;
    int mismatched = 0;
    int wf, wd, wcnt;
    int n_pc, n_ir, n_reg, n_rd, n_wr, n_iord, n_both, n_halt, n_fetch;
    int dst_at_we, m2r_at_we, pcsrc_at_we;
    logic [3:0] trace[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] packed_trace();
        logic [63:0] r = '0;
        foreach (trace[i]) r = {r[59:0], trace[i]};
        return r;
    endfunction

    // memory model: grants an access after wf (fetch) or wd (data) wait cycles; random noise when idle
    task automatic cyc();
        int w;
        @(negedge clk);
        b0.mem_ready = 1'b0;
        #1;
        if (b0.mem_rd || b0.mem_wr) begin
            w = b0.iord ? wd : wf;
            b0.mem_ready = (wcnt >= w);
            wcnt = b0.mem_ready ? 0 : wcnt + 1;
        end else b0.mem_ready = 1'($urandom);
        #1;
        trace.push_back(b0.state);
        n_pc += int'(b0.pc_we);
        n_ir += int'(b0.ir_we);
        n_reg += int'(b0.reg_we);
        n_rd += int'(b0.mem_rd);
        n_wr += int'(b0.mem_wr);
        n_iord += int'(b0.iord);
        n_both += int'(b0.mem_rd && b0.mem_wr);
        n_halt += int'(b0.halted);
        n_fetch += int'(b0.state == 4'd0);
        if (b0.pc_we) pcsrc_at_we = int'(b0.pc_src);
        if (b0.reg_we) begin
            dst_at_we = int'(b0.reg_dst);
            m2r_at_we = int'(b0.mem_to_reg);
        end
        @(posedge clk);
    endtask

    task automatic run_instr(input int op, input bit z, input int f, input int d, input string tag);
        int lat, e_pc, e_pcs;
        lat = (op <= 4) ? 4 + f : (op == 5) ? 5 + f + d : (op == 6) ? 4 + f + d :
              (op == 7 || op == 8) ? 3 + f : 2 + f;
        e_pc = 1 + ((op == 7 && z) ? 1 : 0) + ((op == 8) ? 1 : 0);
        e_pcs = (op == 8) ? 2 : (op == 7 && z) ? 1 : 0;
        wf = f; wd = d; wcnt = 0;
        trace.delete();
        n_pc = 0; n_ir = 0; n_reg = 0; n_rd = 0; n_wr = 0; n_iord = 0; n_both = 0; n_halt = 0; n_fetch = 0;
        dst_at_we = -1; m2r_at_we = -1; pcsrc_at_we = -1;
        b0.opcode = 4'(op);
        b0.zero = z;
        repeat (lat) cyc();
        #1;
        chk({tag, ".end_in_fetch"}, b0.state, 0);
        chk({tag, ".fetch_cycles"}, n_fetch, 1 + f);
        chk({tag, ".pc_we"}, n_pc, e_pc);
        chk({tag, ".pc_src"}, pcsrc_at_we, e_pcs);
        chk({tag, ".ir_we"}, n_ir, 1);
        chk({tag, ".reg_we"}, n_reg, (op <= 5) ? 1 : 0);
        chk({tag, ".reg_dst"}, dst_at_we, (op <= 3) ? 1 : (op <= 5) ? 0 : -1);
        chk({tag, ".mem_to_reg"}, m2r_at_we, (op == 5) ? 1 : (op == 4 || op <= 3) ? 0 : -1);
        chk({tag, ".mem_rd"}, n_rd, 1 + f + ((op == 5) ? 1 + d : 0));
        chk({tag, ".mem_wr"}, n_wr, (op == 6) ? 1 + d : 0);
        chk({tag, ".iord"}, n_iord, (op == 5 || op == 6) ? 1 + d : 0);
        chk({tag, ".rd_wr_overlap"}, n_both, 0);
        chk({tag, ".halted"}, n_halt, 0);
    endtask

    initial begin
        int hcnt, hen;
        b0.opcode = 4'd0;
        b0.zero = 1'b0;
        b0.mem_ready = 1'b0;
        #1;
        chk("reset.state", b0.state, 0);
        chk("reset.mem_rd", b0.mem_rd, 1);
        chk("reset.iord", b0.iord, 0);
        chk("reset.alu_src_b", b0.alu_src_b, 2'b01);
        chk("reset.pc_we", b0.pc_we, 0);
        chk("reset.halted", b0.halted, 0);
        #11;
        rst = 1'b0;

        run_instr(0, 0, 0, 0, "add");
        chk("add.trace", packed_trace(), 64'h0124);
        run_instr(4, 0, 0, 0, "addi");
        chk("addi.trace", packed_trace(), 64'h0134);
        run_instr(5, 0, 0, 3, "lw_wait3");
        chk("lw_wait3.trace", packed_trace(), 64'h01566667);
        run_instr(7, 1, 0, 0, "beq_taken");
        chk("beq_taken.trace", packed_trace(), 64'h019);
        run_instr(7, 0, 0, 0, "beq_not_taken");
        chk("beq_not_taken.trace", packed_trace(), 64'h019);
        run_instr(8, 0, 1, 0, "jump_wait1");
        chk("jump_wait1.trace", packed_trace(), 64'h0001a);
        run_instr(9, 0, 0, 0, "undef_nop");
        chk("undef_nop.trace", packed_trace(), 64'h01);
        run_instr(6, 0, 2, 2, "sw_waits");

        for (int k = 0; k < 40; k++)
            run_instr($urandom_range(0, 14), 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 3), "rand");

        // halt opcode, then asynchronous reset in the middle of a low phase
        b0.opcode = 4'hF;
        wf = 0; wcnt = 0;
        cyc();
        cyc();
        #1;
        chk("halt.state", b0.state, 11);
        repeat (5) cyc();
        #1;
        chk("halt.absorbing", b0.halted, 1);
        @(negedge clk);
        b0.mem_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("halt_rst.state", b0.state, 0);
        chk("halt_rst.halted", b0.halted, 0);
        chk("halt_rst.mem_rd", b0.mem_rd, 1);
        #1;
        rst = 1'b0;

        // reset during a stalled store must drop the write request at once
        b0.opcode = 4'd6;
        wf = 0; wd = 5; wcnt = 0;
        repeat (3) cyc();
        @(negedge clk);
        b0.mem_ready = 1'b0;
        #2;
        chk("st_rst.pre_state", b0.state, 8);
        chk("st_rst.pre_mem_wr", b0.mem_wr, 1);
        rst = 1'b1;
        #1;
        chk("st_rst.mem_wr", b0.mem_wr, 0);
        chk("st_rst.state", b0.state, 0);
        #1;
        rst = 1'b0;

        // undefined opcode on the ILLEGAL_HALT=1 instance
        b0.opcode = 4'd9;
        wf = 0; wcnt = 0;
        hcnt = 0; hen = 0;
        repeat (22) begin
            cyc();
            #1;
            hcnt += int'(b1.halted);
            if (b1.halted) hen += int'(b1.pc_we | b1.ir_we | b1.reg_we | b1.mem_rd | b1.mem_wr);
        end
        chk("illegal_halt.cycles", hcnt, 21);
        chk("illegal_halt.state", b1.state, 11);
        chk("illegal_halt.enables", hen, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
